// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: request/grant/ack front end that shares one single-port
// RAM between the CPU path (A) and the boot loader (B), with a B lock.
module ram_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter bit B_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_gnt,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_din,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_rw,
    output logic              ram_enable,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic owner_b, owner_nx;
    logic last_b, last_nx;
    logic lock_b, lock_nx;
    logic rw_q, rw_nx;
    logic [ADDR_W-1:0] adr_q, adr_nx;
    logic [DATA_W-1:0] din_q, din_nx;
    logic [DATA_W-1:0] rd_q, rd_nx;

    logic a_ok;
    logic pick_a;
    logic pick_b;

    // A is shut out entirely while B holds the lock, even if B is idle
    always_comb begin
        a_ok   = a_req && !(lock_b && b_lock);
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (b_req && a_ok) begin
            if (B_PRIORITY) begin
                pick_b = 1'b1;
            end else begin
                pick_b = !last_b;
                pick_a = last_b;
            end
        end else begin
            pick_a = a_ok;
            pick_b = b_req;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner_b;
        last_nx  = last_b;
        lock_nx  = lock_b;
        rw_nx    = rw_q;
        adr_nx   = adr_q;
        din_nx   = din_q;
        rd_nx    = rd_q;
        if (ce) begin
            unique case (state)
                IDLE: begin
                    if (!b_lock) lock_nx = 1'b0;
                    if (pick_b) begin
                        state_nx = ACCESS;
                        owner_nx = 1'b1;
                        rw_nx    = b_rw;
                        adr_nx   = b_adr;
                        din_nx   = b_din;
                        if (b_lock) lock_nx = 1'b1;
                    end else if (pick_a) begin
                        state_nx = ACCESS;
                        owner_nx = 1'b0;
                        rw_nx    = a_rw;
                        adr_nx   = a_adr;
                        din_nx   = a_din;
                    end
                end
                ACCESS: begin
                    state_nx = WAIT;
                end
                WAIT: begin
                    if (!rw_q) rd_nx = ram_out;
                    state_nx = DONE;
                end
                DONE: begin
                    last_nx  = owner_b;
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
            lock_b  <= 1'b0;
            rw_q    <= 1'b0;
            adr_q   <= '0;
            din_q   <= '0;
            rd_q    <= '0;
        end else begin
            state   <= state_nx;
            owner_b <= owner_nx;
            last_b  <= last_nx;
            lock_b  <= lock_nx;
            rw_q    <= rw_nx;
            adr_q   <= adr_nx;
            din_q   <= din_nx;
            rd_q    <= rd_nx;
        end
    end

    // write strobe is only presented while the RAM is enabled
    assign busy       = (state != IDLE);
    assign a_gnt      = busy && !owner_b;
    assign b_gnt      = busy && owner_b;
    assign a_ack      = (state == DONE) && !owner_b;
    assign b_ack      = (state == DONE) && owner_b;
    assign ram_enable = (state == ACCESS);
    assign ram_rw     = rw_q && (state == ACCESS);
    assign ram_adr    = adr_q;
    assign ram_in     = din_q;
    assign rd_data    = rd_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed scoreboard bench for the
// RAM port arbiter, with a behavioural RAM and memory reference model.
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] adr;
        logic [DW-1:0] din;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic a_req, a_rw, a_gnt, a_ack;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_din;
    logic b_req, b_rw, b_lock, b_gnt, b_ack;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_din;
    logic [DW-1:0] rd_data, ram_in, ram_out;
    logic [AW-1:0] ram_adr;
    logic busy, ram_rw, ram_enable;

    ram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .B_PRIORITY(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .a_req(a_req), .a_rw(a_rw), .a_adr(a_adr), .a_din(a_din),
        .a_gnt(a_gnt), .a_ack(a_ack),
        .b_req(b_req), .b_rw(b_rw), .b_adr(b_adr), .b_din(b_din),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_ack(b_ack),
        .rd_data(rd_data), .busy(busy),
        .ram_adr(ram_adr), .ram_in(ram_in), .ram_rw(ram_rw),
        .ram_enable(ram_enable), .ram_out(ram_out)
    );

    logic rr_a_req, rr_a_rw, rr_a_gnt, rr_a_ack;
    logic [AW-1:0] rr_a_adr;
    logic [DW-1:0] rr_a_din;
    logic rr_b_req, rr_b_rw, rr_b_lock, rr_b_gnt, rr_b_ack;
    logic [AW-1:0] rr_b_adr;
    logic [DW-1:0] rr_b_din;
    logic [DW-1:0] rr_rd_data, rr_ram_in, rr_ram_out;
    logic [AW-1:0] rr_ram_adr;
    logic rr_busy, rr_ram_rw, rr_ram_enable;

    assign rr_ram_out = {10'h0, rr_ram_adr};

    ram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .B_PRIORITY(1'b0)
    ) dut_rr (
        .clk(clk), .rst(rst), .ce(ce),
        .a_req(rr_a_req), .a_rw(rr_a_rw), .a_adr(rr_a_adr),
        .a_din(rr_a_din), .a_gnt(rr_a_gnt), .a_ack(rr_a_ack),
        .b_req(rr_b_req), .b_rw(rr_b_rw), .b_adr(rr_b_adr),
        .b_din(rr_b_din), .b_lock(rr_b_lock), .b_gnt(rr_b_gnt),
        .b_ack(rr_b_ack), .rd_data(rr_rd_data), .busy(rr_busy),
        .ram_adr(rr_ram_adr), .ram_in(rr_ram_in), .ram_rw(rr_ram_rw),
        .ram_enable(rr_ram_enable), .ram_out(rr_ram_out)
    );

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 16'h1234;
        return 16'hA000 ^ 16'(i * 257);
    endfunction

    // behavioural single-port RAM on the shared clock enable
    logic [DW-1:0] mem [64];
    bit ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (rst && !ram_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else if (ce && ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else ram_out <= mem[ram_adr];
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] outs();
        return {a_gnt, a_ack, b_gnt, b_ack, busy, ram_rw, ram_enable,
                rd_data, ram_adr, ram_in};
    endfunction

    // scoreboard state
    txn_t qa[$];
    txn_t qb[$];
    logic [DW-1:0] ref_mem [64];
    bit ref_init = 1'b0;
    logic [DW-1:0] exp_rd;
    int en_cnt;
    bit lock_m;
    bit pend_v;
    logic [1:0] pend_own;

    task automatic retire(input bit pb);
        txn_t t;
        if ((pb && qb.size() == 0) || (!pb && qa.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack port_b=%0d actual=ack required=none", pb);
            return;
        end
        if (pb) t = qb.pop_front();
        else t = qa.pop_front();
        check("enable_pulses", 64'(en_cnt), 64'd1);
        en_cnt = 0;
        check("ram_adr_captured", 64'(ram_adr), 64'(t.adr));
        if (t.rw) begin
            ref_mem[t.adr] = t.din;
            check("ram_in_captured", 64'(ram_in), 64'(t.din));
        end else begin
            exp_rd = ref_mem[t.adr];
        end
        check(pb ? "b_rd_data" : "a_rd_data", 64'(rd_data), 64'(exp_rd));
    endtask

    // monitor: owner prediction from the arbitration rules, ack retirement
    always @(negedge clk) begin
        if (rst) begin
            if (!ref_init) begin
                for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
                ref_init = 1'b1;
            end
            qa.delete();
            qb.delete();
            exp_rd = '0;
            en_cnt = 0;
            lock_m = 1'b0;
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                check("grant_owner", 64'({b_gnt, a_gnt}), 64'(pend_own));
                pend_v = 1'b0;
            end
            check("gnt_onehot", 64'(a_gnt & b_gnt), 64'd0);
            check("ack_onehot", 64'(a_ack & b_ack), 64'd0);
            check("rw_only_in_access", 64'(ram_rw & ~ram_enable), 64'd0);
            if (ce) begin
                if (ram_enable) en_cnt++;
                if (a_ack) retire(1'b0);
                if (b_ack) retire(1'b1);
                if (!busy) begin
                    if (!b_lock) lock_m = 1'b0;
                    if (b_req) pend_own = 2'b10;
                    else if (a_req && !(lock_m && b_lock)) pend_own = 2'b01;
                    else pend_own = 2'b00;
                    if (b_req && b_lock) lock_m = 1'b1;
                    pend_v = 1'b1;
                end
            end
        end
    end

    bit rr_active = 1'b0;
    int rr_seq[$];
    int rr_t[$];
    always @(negedge clk) begin
        if (!rst && rr_active) begin
            check("rr_gnt_onehot", 64'(rr_a_gnt & rr_b_gnt), 64'd0);
            if (ce && rr_a_ack) begin
                rr_seq.push_back(0);
                rr_t.push_back(cyc_cnt);
            end
            if (ce && rr_b_ack) begin
                rr_seq.push_back(1);
                rr_t.push_back(cyc_cnt);
            end
        end
    end

    task automatic wait_ack(input bit pb, input int lim, output int n);
        n = 0;
        while ((pb ? b_ack : a_ack) && n < lim) begin
            cyc();
            n++;
        end
        n = 0;
        while (!(pb ? b_ack : a_ack) && n < lim) begin
            cyc();
            n++;
        end
        if (n >= lim) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout port_b=%0d actual=none required=ack", pb);
        end
    endtask

    task automatic issue(input bit pb, input txn_t t, input bit lock);
        if (pb) begin
            b_rw = t.rw; b_adr = t.adr; b_din = t.din;
            b_lock = lock; b_req = 1'b1;
            qb.push_back(t);
        end else begin
            a_rw = t.rw; a_adr = t.adr; a_din = t.din;
            a_req = 1'b1;
            qa.push_back(t);
        end
    endtask

    task automatic txn(input bit pb, input logic rw, input logic [AW-1:0] adr,
                       input logic [DW-1:0] din, input bit lock, output int lat);
        txn_t t;
        t.rw = rw; t.adr = adr; t.din = din;
        issue(pb, t, lock);
        wait_ack(pb, 200, lat);
        if (pb) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    task automatic drive(input bit pb, input int n);
        txn_t t;
        int w;
        for (int k = 0; k < n; k++) begin
            t.rw  = 1'($urandom_range(0, 1));
            t.adr = 6'($urandom_range(0, 7));
            t.din = 16'($urandom);
            issue(pb, t, pb && ($urandom_range(0, 3) == 0));
            wait_ack(pb, 1500, w);
            if ($urandom_range(0, 1) == 0) begin
                if (pb) b_req = 1'b0;
                else a_req = 1'b0;
                repeat ($urandom_range(1, 4)) cyc();
            end
        end
        if (pb) begin
            b_req = 1'b0;
            b_lock = 1'b0;
        end else begin
            a_req = 1'b0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int lat;
    int na;
    int nb;
    int n;
    bit rand_on;
    bit ce_pat_on;

    initial begin
        rst = 1'b1; ce = 1'b1;
        a_req = 0; a_rw = 0; a_adr = '0; a_din = '0;
        b_req = 0; b_rw = 0; b_adr = '0; b_din = '0; b_lock = 0;
        rr_a_req = 0; rr_a_rw = 0; rr_a_adr = 6'd3; rr_a_din = '0;
        rr_b_req = 0; rr_b_rw = 1; rr_b_adr = 6'd4; rr_b_din = 16'h55AA;
        rr_b_lock = 0;
        repeat (3) cyc();
        rst = 1'b0;
        check("reset_outputs", outs(), 64'd0);

        txn(0, 1'b0, 6'h05, 16'h0, 0, lat);
        check("a_read_latency", 64'(lat), 64'd3);
        check("a_read_0x05", 64'(rd_data), 64'h1234);
        cyc();
        txn(1, 1'b1, 6'h3F, 16'hBEEF, 0, lat);
        check("b_write_latency", 64'(lat), 64'd3);
        check("rd_hold_after_write", 64'(rd_data), 64'h1234);
        cyc();
        txn(0, 1'b0, 6'h3F, 16'h0, 0, lat);
        check("a_read_0x3f", 64'(rd_data), 64'hBEEF);
        cyc();

        // B locks the RAM; A must wait even while B is idle
        txn(1, 1'b0, 6'h01, 16'h0, 1, lat);
        cyc();
        issue(0, '{rw: 1'b0, adr: 6'h02, din: 16'h0}, 0);
        na = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (3) begin
                cyc();
                na += int'(a_gnt);
            end
            txn(1, 1'(k), 6'(10 + k), 16'(16'h0F00 + k), 1, lat);
            na += int'(a_gnt);
            cyc();
            na += int'(a_gnt);
        end
        check("lock_blocks_a", 64'(na), 64'd0);
        b_lock = 1'b0;
        cyc();
        check("a_granted_after_unlock", 64'(a_gnt), 64'd1);
        wait_ack(0, 50, n);
        a_req = 1'b0;
        repeat (2) cyc();

        // clock enable stretching during an A read
        ce_pat_on = 1'b1;
        fork
            begin
                int i = 0;
                while (ce_pat_on) begin
                    ce = (i % 3 == 0);
                    i++;
                    cyc();
                end
                ce = 1'b1;
            end
            begin
                txn(0, 1'b0, 6'h3F, 16'h0, 0, lat);
                ce_pat_on = 1'b0;
            end
        join
        check("ce_stretch_latency", 64'(lat > 3), 64'd1);
        check("ce_stretch_data", 64'(rd_data), 64'hBEEF);
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        repeat (4) cyc();

        // reset while a B read sits in WAIT
        issue(1, '{rw: 1'b0, adr: 6'h09, din: 16'h0}, 0);
        cyc();
        cyc();
        check("b_read_in_wait", 64'({busy, b_gnt, ram_enable}), 64'b110);
        rst = 1'b1;
        b_req = 1'b0;
        cyc();
        rst = 1'b0;
        check("reset_mid_txn_outputs", outs(), 64'd0);
        nb = 0;
        repeat (6) begin
            cyc();
            nb += int'(b_ack);
        end
        check("no_b_ack_after_reset", 64'(nb), 64'd0);
        txn(0, 1'b0, 6'h09, 16'h0, 0, lat);
        check("a_read_after_reset_latency", 64'(lat), 64'd3);
        check("a_read_after_reset_data", 64'(rd_data), 64'(init_val(9)));
        cyc();

        // randomized traffic from both ports with a random clock enable
        rand_on = 1'b1;
        fork
            begin
                fork
                    drive(0, 30);
                    drive(1, 30);
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    ce = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                ce = 1'b1;
            end
        join
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        check("queues_drained", 64'(qa.size() + qb.size()), 64'd0);

        // round-robin instance with both ports requesting continuously
        rr_active = 1'b1;
        rr_a_req = 1'b1;
        rr_b_req = 1'b1;
        repeat (40) cyc();
        rr_active = 1'b0;
        rr_a_req = 1'b0;
        rr_b_req = 1'b0;
        repeat (6) cyc();
        check("rr_ack_count", 64'(rr_seq.size() >= 8), 64'd1);
        for (int i = 0; i < rr_seq.size(); i++) begin
            check("rr_order", 64'(rr_seq[i]), 64'(i % 2));
            if (i >= 2) check("rr_period", 64'(rr_t[i] - rr_t[i-2]), 64'd8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 64x16 program/data RAM between two requesters. Port A is the CPU control unit fetch/execute path. Port B is the UART boot loader / memory scanner.
- Replaces the hard `boot`-select mux with a request/grant/ack transaction engine.
- Adds round-robin or fixed-priority arbitration, plus a lock so the boot loader can own the RAM for a whole program load.
- Sits between the requesters and the RAM instance. Runs on the shared clock enable.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 16, RAM data width.
- B_PRIORITY, 1. 1 = port B wins simultaneous requests. 0 = round-robin.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; all state advances only when ce=1
- a_req  in  1  port A transaction request
- a_rw  in  1  port A direction, 1=write, 0=read
- a_adr  in  ADDR_W  port A address
- a_din  in  DATA_W  port A write data
- a_gnt  out  1  port A owns current transaction
- a_ack  out  1  port A transaction complete (1 ce-cycle pulse)
- b_req  in  1  port B request
- b_rw  in  1  port B direction
- b_adr  in  ADDR_W  port B address
- b_din  in  DATA_W  port B write data
- b_lock  in  1  port B holds ownership across transactions
- b_gnt  out  1  port B owns current transaction
- b_ack  out  1  port B transaction complete
- rd_data  out  DATA_W  registered read data, shared by both ports
- busy  out  1  transaction in flight (state != IDLE)
- ram_adr  out  ADDR_W  to RAM add
- ram_in  out  DATA_W  to RAM data_in
- ram_rw  out  1  to RAM r_w
- ram_enable  out  1  to RAM enable
- ram_out  in  DATA_W  from RAM data_out

Behaviour:
- Reset: rst takes effect at the clock edge regardless of ce.
  - Outputs: all 0; ram_rw=0 (read).
  - Internal: state=IDLE, last_owner=B, lock_owner=none.
- ce=0: all registers hold and outputs are unchanged. A transaction is simply stretched; nothing is dropped.
- FSM states, each transition on a ce=1 edge:
  - IDLE: sample a_req/b_req and pick a winner. Capture the winner's rw/adr/din into ram_adr/ram_rw/ram_in. Set the winner's gnt. Go to ACCESS. No request: stay in IDLE.
  - ACCESS: ram_enable=1 for exactly this state. Go to WAIT.
  - WAIT: ram_enable=0. On a read, capture ram_out into rd_data at this edge. On a write, rd_data holds its prior value. Go to DONE.
  - DONE: winner's ack=1, gnt stays 1. At the edge, clear gnt and update last_owner. Go to IDLE.
- Latency: request sampled in IDLE at edge N gives ack high during the cycle after edge N+2 (3 ce-cycles). rd_data is valid from the ack cycle until the next read completes.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, B_PRIORITY=1: B wins.
  - Both requesting, B_PRIORITY=0: the port not equal to last_owner wins. First tie after reset goes to A.
- Lock:
  - When B is granted with b_lock=1, set lock_owner=B.
  - While lock_owner=B and b_lock=1, A is never granted, even with b_req=0.
  - Clear lock_owner in IDLE when b_lock=0.
- Requester rules:
  - Hold req and fields stable until ack.
  - A requester may keep req high through ack to issue the next transaction. Its fields must be updated by the DONE cycle; the next IDLE samples them.
  - Fields are registered, so later changes do not affect an in-flight transaction.
- The losing requester's req remains pending, with no starvation under round-robin.
- At most one of a_gnt/b_gnt and at most one of a_ack/b_ack is high in any cycle.
- Reset mid-transaction: the transaction is abandoned, ack never issues, outputs return to reset values next cycle.
- A request withdrawn during ACCESS/WAIT is ignored; the transaction still completes and acks.

Test Plan:
- Reset, then A read at adr=0x05 (RAM holds 0x1234), ce=1 → ram_enable high exactly 1 cycle, a_ack 3 cycles after sample, rd_data=0x1234, b_gnt=0 throughout.
- B write adr=0x3F din=0xBEEF, then A read 0x3F → ram_rw=1 in ACCESS only; A reads 0xBEEF; rd_data unchanged after the write.
- B_PRIORITY=0, a_req and b_req held high continuously → grants alternate A,B,A,B; each port gets an ack every 8 cycles with 4-cycle transactions.
- B_PRIORITY=1, b_lock=1 with intermittent b_req, a_req held high → a_gnt never asserts; b_lock drops → A granted in next IDLE.
- ce toggled 1,0,0,1… during an A read → FSM stretches, ram_enable high for exactly 1 ce=1 cycle, correct rd_data, single a_ack.
- rst asserted during WAIT of a B read → next cycle all outputs 0, no b_ack; subsequent A read completes normally.
